// File: rtl/clock_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clock_div_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int DEFAULT_DIV_DEF = 3;
  localparam int MIN_DIV         = 2;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    CHANGE = 2'd2
  } state_t;

endpackage

// File: rtl/clock_div_ctrl_if.sv
// Ratio-change handshake between configuration logic and the divider.
interface clock_div_ctrl_if
  import clock_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_div, input  cfg_ready, cfg_err);
  modport slave  (input  cfg_valid, cfg_div, output cfg_ready, cfg_err);

endinterface

// File: rtl/clock_div_core.sv
// Period counter and two-edge phase generator producing a 50% duty divided clock.
module clock_div_core
  import clock_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             clock_out,
  output logic             wrap,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] half;
  logic             active;
  logic             pos_hi;
  logic             neg_hi;

  assign half = div >> 1;
  assign wrap = active && (cnt == div - CNT_W'(1));

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    if (!active || wrap) cnt_nxt = '0;
  end

  // pos_hi and tick are registered from cnt_nxt so they line up with the new count
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      pos_hi <= 1'b0;
      tick   <= 1'b0;
    end else if (!run) begin
      active <= 1'b0;
      cnt    <= '0;
      pos_hi <= 1'b0;
      tick   <= 1'b0;
    end else begin
      active <= 1'b1;
      cnt    <= cnt_nxt;
      pos_hi <= (cnt_nxt < half);
      tick   <= (cnt_nxt == '0);
    end
  end

  // Half-cycle stretch for odd ratios
  always_ff @(negedge clock_in or posedge reset) begin
    if (reset) neg_hi <= 1'b0;
    else       neg_hi <= pos_hi;
  end

  assign clock_out = pos_hi | (div[0] & neg_hi);

endmodule

// File: rtl/clock_div_ctrl.sv
// Divider sequencer: run/stop FSM, ratio handshake, pending ratio and lock status.
module clock_div_ctrl
  import clock_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   enable,
  clock_div_ctrl_if.slave        cfg,
  output logic                   clock_out,
  output logic                   tick,
  output logic [CNT_W-1:0]       cur_div,
  output logic                   locked
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] pending;
  logic             wrap;
  logic             run;
  logic             xfer;
  logic             bad_div;

  assign xfer    = cfg.cfg_valid & cfg.cfg_ready;
  assign bad_div = cfg.cfg_div < CNT_W'(MIN_DIV);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) state <= STOP;
    else       state <= state_nxt;
  end

  // enable and ratio swaps only take effect at a period boundary (wrap)
  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (enable) state_nxt = RUN;
      RUN: begin
        if (wrap && !enable)      state_nxt = STOP;
        else if (xfer && !bad_div) state_nxt = CHANGE;
      end
      CHANGE:  if (wrap) state_nxt = enable ? RUN : STOP;
      default: state_nxt = STOP;
    endcase
  end

  // Core starts one cycle after RUN entry and stops on the boundary edge itself
  always_comb begin
    cfg.cfg_ready = (state != CHANGE);
    run           = (state != STOP) && (state_nxt != STOP);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      cur_div     <= CNT_W'(DEFAULT_DIV);
      pending     <= '0;
      locked      <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= xfer && bad_div;
      if (xfer && !bad_div) begin
        if (state == STOP || state_nxt == STOP) cur_div <= cfg.cfg_div;
        else                                    pending <= cfg.cfg_div;
      end
      if (state == CHANGE && wrap) cur_div <= pending;
      if (state_nxt == STOP)           locked <= 1'b0;
      else if (xfer && !bad_div)       locked <= 1'b0;
      else if (state == RUN && wrap)   locked <= 1'b1;
    end
  end

  clock_div_core #(.CNT_W(CNT_W)) u_core (
    .clock_in  (clock_in),
    .reset     (reset),
    .run       (run),
    .div       (cur_div),
    .clock_out (clock_out),
    .wrap      (wrap),
    .tick      (tick)
  );

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Self-checking bench for clock_div_ctrl against a period-list reference model.
module tb_clock_div_ctrl;

  localparam int CNT_W = 8;

  logic             clock_in = 1'b0;
  logic             reset    = 1'b0;
  logic             enable   = 1'b0;
  logic             clock_out;
  logic             tick;
  logic             locked;
  logic [CNT_W-1:0] cur_div;

  int n_tests = 0;
  int n_fail  = 0;

  // One record per source cycle: {tick, clk@pos half, clk@neg half, locked, ready, err, cur_div}
  logic [CNT_W+5:0] rec[$];
  logic [CNT_W+5:0] exp_v[$];

  clock_div_ctrl_if #(.CNT_W(CNT_W)) cfg ();

  clock_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(3)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .enable    (enable),
    .cfg       (cfg),
    .clock_out (clock_out),
    .tick      (tick),
    .cur_div   (cur_div),
    .locked    (locked)
  );

  always #5 clock_in = ~clock_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    logic t, hp, lk, rd, er;
    logic [CNT_W-1:0] d;
    @(posedge clock_in); #2;
    t = tick; hp = clock_out; lk = locked; rd = cfg.cfg_ready; er = cfg.cfg_err; d = cur_div;
    @(negedge clock_in); #2;
    rec.push_back({t, hp, clock_out, lk, rd, er, d});
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_div = '0;
    @(negedge clock_in); #2;
    reset = 1'b0;
    rec.delete();
  endtask

  // Enable at index -1; optional transfer driven at index xt, enable drop at index dt.
  task automatic run_stim(input int n0, input int xt, input int m, input int dt,
                          input int ncyc, input bit fresh);
    if (fresh) begin
      do_reset();
      if (n0 != 3) begin
        cfg.cfg_valid = 1'b1; cfg.cfg_div = CNT_W'(n0);
        step();
        cfg.cfg_valid = 1'b0;
      end
    end
    rec.delete();
    enable = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (i == xt) begin
        cfg.cfg_valid = 1'b1; cfg.cfg_div = CNT_W'(m);
      end else if (i == xt + 1) begin
        cfg.cfg_valid = 1'b0;
      end
      if (i == dt) enable = 1'b0;
    end
    cfg.cfg_valid = 1'b0;
  endtask

  // Reference: list of clock_out periods; each period of length L is high for L half-cycles.
  task automatic build_model(input int n0, input int xt, input int m, input int dt, input int ncyc);
    int ps[$];
    int pl[$];
    int s, cur, b, stop_at, chg_at, ph, d;
    bit chg;
    logic t, hp, hn, lk, rd, er;
    exp_v.delete();
    s = 1; cur = n0; stop_at = -1; chg_at = -1;
    chg = (xt >= 0) && (m >= 2);
    while (s < ncyc) begin
      ps.push_back(s); pl.push_back(cur);
      b = s + cur;
      if (dt >= 0 && b >= dt + 1) begin stop_at = b; break; end
      if (chg && chg_at < 0 && b > xt + 1) begin chg_at = b; cur = m; end
      s = b;
    end
    for (int i = 0; i < ncyc; i++) begin
      t = 1'b0; hp = 1'b0; hn = 1'b0;
      for (int j = 0; j < ps.size(); j++) begin
        if (i >= ps[j] && i < ps[j] + pl[j]) begin
          ph = i - ps[j];
          t  = (ph == 0);
          hp = (2 * ph < pl[j]);
          hn = (2 * ph + 1 < pl[j]);
        end
      end
      lk = (i >= 1 + n0);
      if (chg && i >= xt + 1) lk = (chg_at >= 0 && i >= chg_at + m);
      if (stop_at >= 0 && i >= stop_at) lk = 1'b0;
      rd = !(chg && i >= xt + 1 && (chg_at < 0 || i < chg_at));
      er = (xt >= 0 && m < 2 && i == xt + 1);
      d  = (chg_at >= 0 && i >= chg_at) ? m : n0;
      exp_v.push_back({t, hp, hn, lk, rd, er, CNT_W'(d)});
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_tests++; if (clock_out !== 1'b0) begin n_fail++; $display("FAIL reset_clock_out: got %b want 0", clock_out); end
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_tests++; if (cfg.cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err: got %b want 0", cfg.cfg_err); end
    n_tests++; if (cfg.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 1", cfg.cfg_ready); end
    n_tests++; if (cur_div !== 8'd3) begin n_fail++; $display("FAIL reset_cur_div: got %0d want 3", cur_div); end
    enable = 1'b1;
    @(negedge clock_in); #2;
    n_tests++; if (clock_out !== 1'b0) begin n_fail++; $display("FAIL reset_held_clock_out: got %b want 0", clock_out); end
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_held_tick: got %b want 0", tick); end
    enable = 1'b0;
  endtask

  task automatic test_n3();
    run_stim(3, -1, 0, -1, 20, 1'b1);
    build_model(3, -1, 0, -1, 20);
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (rec[i] !== exp_v[i]) begin n_fail++; $display("FAIL n3_run cycle %0d: got %b want %b", i, rec[i], exp_v[i]); end
    end
  endtask

  task automatic test_change();
    run_stim(4, 6, 5, -1, 30, 1'b1);
    build_model(4, 6, 5, -1, 30);
    for (int i = 0; i < 30; i++) begin
      n_tests++;
      if (rec[i] !== exp_v[i]) begin n_fail++; $display("FAIL change_4_to_5 cycle %0d: got %b want %b", i, rec[i], exp_v[i]); end
    end
  endtask

  task automatic test_cfg_err();
    run_stim(4, 7, 1, -1, 20, 1'b1);
    build_model(4, 7, 1, -1, 20);
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (rec[i] !== exp_v[i]) begin n_fail++; $display("FAIL cfg_err cycle %0d: got %b want %b", i, rec[i], exp_v[i]); end
    end
  endtask

  task automatic test_stop();
    run_stim(6, -1, 0, 8, 30, 1'b1);
    build_model(6, -1, 0, 8, 30);
    for (int i = 0; i < 30; i++) begin
      n_tests++;
      if (rec[i] !== exp_v[i]) begin n_fail++; $display("FAIL stop_n6 cycle %0d: got %b want %b", i, rec[i], exp_v[i]); end
    end
  endtask

  task automatic test_stop_cfg();
    do_reset();
    n_tests++; if (cur_div !== 8'd3) begin n_fail++; $display("FAIL stop_cfg_before: got %0d want 3", cur_div); end
    cfg.cfg_valid = 1'b1; cfg.cfg_div = 8'd2;
    step();
    cfg.cfg_valid = 1'b0;
    n_tests++; if (rec[0][CNT_W-1:0] !== 8'd2) begin n_fail++; $display("FAIL stop_cfg_cur_div: got %0d want 2", rec[0][CNT_W-1:0]); end
    n_tests++; if (rec[0][CNT_W] !== 1'b0) begin n_fail++; $display("FAIL stop_cfg_err: got %b want 0", rec[0][CNT_W]); end
    run_stim(2, -1, 0, -1, 12, 1'b0);
    build_model(2, -1, 0, -1, 12);
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (rec[i] !== exp_v[i]) begin n_fail++; $display("FAIL stop_cfg_n2 cycle %0d: got %b want %b", i, rec[i], exp_v[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset();
    cfg.cfg_valid = 1'b1; cfg.cfg_div = 8'd5;
    step();
    cfg.cfg_valid = 1'b0;
    enable = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (rec[rec.size()-1][CNT_W+5] && rec[rec.size()-1][CNT_W+2]) found = 1'b1;
    end
    n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL reset_mid_wait_lock: got %b want 1", found); end
    n_tests++; if (clock_out !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre_high: got %b want 1", clock_out); end
    reset = 1'b1;
    #1;
    n_tests++; if (clock_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid_clock_out: got %b want 0", clock_out); end
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_mid_tick: got %b want 0", tick); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_mid_locked: got %b want 0", locked); end
    n_tests++; if (cfg.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b want 1", cfg.cfg_ready); end
    n_tests++; if (cur_div !== 8'd3) begin n_fail++; $display("FAIL reset_mid_cur_div: got %0d want 3", cur_div); end
    @(negedge clock_in); #2;
    reset = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_random();
    int n0, mode, xt, m, dt, ncyc;
    for (int it = 0; it < 12; it++) begin
      n0 = $urandom_range(2, 9);
      mode = $urandom_range(0, 2);
      xt = -1; m = 0; dt = -1;
      if (mode == 1) begin xt = $urandom_range(0, 3 * n0); m = $urandom_range(0, 9); end
      if (mode == 2) dt = $urandom_range(0, 3 * n0);
      ncyc = 5 + 4 * n0 + 18;
      run_stim(n0, xt, m, dt, ncyc, 1'b1);
      build_model(n0, xt, m, dt, ncyc);
      for (int i = 0; i < ncyc; i++) begin
        n_tests++;
        if (rec[i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL random it%0d n0=%0d xt=%0d m=%0d dt=%0d cycle %0d: got %b want %b",
                   it, n0, xt, m, dt, i, rec[i], exp_v[i]);
        end
      end
    end
  endtask

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div   = '0;
    test_reset();
    test_n3();
    test_change();
    test_cfg_err();
    test_stop();
    test_stop_cfg();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_div_ctrl.md
Name: clock_div_ctrl

Overview:
- Programmable integer clock divider with a configuration sequencer.
- Produces a 50%-duty `clock_out` from `clock_in` for any ratio N ≥ 2. Odd N uses a negative-edge half-cycle stretch.
- Ratio changes arrive over a valid/ready handshake and are applied only at period boundaries, so `clock_out` never shows a runt or glitch.
- Sits between the system configuration logic and downstream consumers of the divided clock and its enable pulse.

Parameters:
- CNT_W, 8: width of the ratio and the period counter.
- DEFAULT_DIV, 3: ratio loaded on reset. Must be in 2..2^CNT_W-1.

Ports:
- clock_in  input  1  source clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run request. 1 = divider runs; 0 = stop at the next period boundary.
- cfg_valid  input  1  new-ratio request valid.
- cfg_div  input  CNT_W  requested ratio N.
- cfg_ready  output  1  block can accept a ratio this cycle.
- cfg_err  output  1  one-cycle pulse: the accepted request had cfg_div < 2 and was discarded.
- clock_out  output  1  divided clock.
- tick  output  1  one-cycle pulse in the clock_in domain at each `clock_out` rising edge.
- cur_div  output  CNT_W  ratio currently in effect.
- locked  output  1  `clock_out` is running at `cur_div` and has completed one full period at that ratio.

Behaviour:
- Reset (asynchronous, all flops, both edges):
  - state = STOP, cnt = 0, cur_div = DEFAULT_DIV, pending = 0.
  - clock_out = 0, tick = 0, locked = 0, cfg_err = 0, cfg_ready = 1.
  - Reset mid-period forces clock_out low immediately; no completion of the period.
- Posedge state machine:
  - STOP: cnt held at 0, pos_hi = 0.
    - enable = 1 → RUN, with the first tick and clock_out rise on the next cycle.
  - RUN: cnt counts 0..N-1 and wraps. The wrap (cnt == N-1) is the period boundary.
    - tick = 1 in the cycle where cnt == 0.
    - enable = 0 at a boundary → STOP, locked = 0.
  - CHANGE: entered when a ratio is accepted in RUN. Counting continues at the old N.
    - At the boundary: cur_div ← pending, then → RUN, or → STOP if enable = 0.
- Phase generation (N = cur_div):
  - pos_hi is a posedge register, high for cnt < floor(N/2).
  - neg_hi is pos_hi resampled on negedge clock_in.
  - clock_out = pos_hi | (N[0] & neg_hi). Result: high time is N/2 source cycles, exactly 50% duty for both even and odd N.
  - clock_out is glitch-free: no combinational path from cnt to clock_out.
- Handshake:
  - cfg_ready = 1 in STOP and RUN, 0 in CHANGE. A transfer occurs when cfg_valid & cfg_ready.
  - STOP transfer: cur_div updates the next cycle.
  - RUN transfer: pending ← cfg_div, → CHANGE, locked → 0 the next cycle.
  - Transfer with cfg_div < 2: cfg_err pulses one cycle later, no state or ratio change.
  - cfg_div equal to cur_div is treated as a normal change (locked drops and re-locks).
  - A transfer in the same cycle as a boundary takes effect at the following boundary.
- locked:
  - Sets at the first boundary after entering RUN, and at the first boundary after a CHANGE completes.
  - Clears on STOP entry, on a RUN transfer, and on reset.
- enable behaviour:
  - Drops within a period: the period completes, no runt.
  - Re-asserted before the boundary: ignored, the divider keeps running.
- Latency:
  - enable → first clock_out rise: 2 clock_in cycles.
  - Accepted change in RUN: applied at most N_old cycles later.

Decomposition:
- Package clock_div_pkg:
  - state enum {STOP, RUN, CHANGE}
  - MIN_DIV = 2
  - default CNT_W and DEFAULT_DIV
- Sub-module clock_div_core:
  - Contains the counter, pos_hi/neg_hi and output OR.
  - Inputs: run, div.
  - Outputs: clock_out, wrap, tick.
  - clock_div_ctrl holds the FSM, handshake, pending register and locked.

Test Plan:
- Reset, enable = 1, N = 3 → clock_out period 3 cycles, high 1.5 cycles; tick every 3 cycles; locked = 1 after the first boundary.
- N = 4 running, accept cfg_div = 5 mid-period → next boundary at cnt = 3, then period 5 with 2.5 high. cfg_ready is 0 in CHANGE. locked drops and re-asserts 5 cycles after the swap.
- cfg_div = 1 with cfg_valid → cfg_err pulses once; cur_div is unchanged; clock_out is undisturbed.
- N = 6, drop enable at cnt = 1 → clock_out completes its high 3 and low 3 then stays 0; locked = 0; no runt pulse.
- In STOP, accept cfg_div = 2, then enable → period 2 with 1 high 1 low; cur_div = 2 the cycle after transfer.
- Assert reset with clock_out high mid-period → clock_out = 0 and all outputs at reset values asynchronously; cur_div = 3.
